// File: rtl/l1i_port_arbiter.sv
// -----------------------------------------------------------------------------
// l1i_port_arbiter
//
// This block sits in front of the single-port L1 instruction cache memory. It
// merges fetch-stage lookups and miss-handler line fills onto the memory's
// mutually exclusive read and write ports.
//  - Reads and writes never collide.
//  - A write never issues in the cycle right after a read. One bubble cycle
//    (TURN) is inserted instead.
//  - Address fields of the unused port are driven to zero, so the memory's
//    OR-combined index is always correct.
//  - Fills normally win arbitration. After fillBurstMax back-to-back fill
//    grants, a waiting fetch gets one slot. This bounds fetch starvation.
//
// Ports
//   clock_i, reset_i            clock, synchronous active-high reset
//   flushPipeline_i             suppresses fetch grants (fills still proceed)
//   fetchReq_i, fetch*          lookup request and address (held until granted)
//   fetchGrant_o                combinational: lookup accepted this cycle
//   fillReq_i, fill*            line-fill request, data and address
//   fillGrant_o                 combinational: fill accepted this cycle
//   fetchEnable_o, tag_o, index_o, offset_o
//                               registered memory read port
//   updateEnable_o, newCacheline_o, newTag_o, newIndex_o, newOffset_o
//                               registered memory write port
//   turnaroundCount_o           (only with L1I_ARB_PERF_EN) saturating count
//                               of TURN cycles; cleared by reset only
//
// Optional feature macro: L1I_ARB_PERF_EN
// -----------------------------------------------------------------------------
module l1i_port_arbiter #(
   parameter int offsetSize          = 5,
   parameter int indexSize           = 8,
   parameter int tagSize             = 64 - (offsetSize + indexSize),
   parameter int cachelineSizeInBits = (2 ** offsetSize) * 8,
   parameter int fillBurstMax        = 4
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           flushPipeline_i,

   input  logic                           fetchReq_i,
   input  logic [tagSize-1:0]             fetchTag_i,
   input  logic [indexSize-1:0]           fetchIndex_i,
   input  logic [offsetSize-1:0]          fetchOffset_i,
   output logic                           fetchGrant_o,

   input  logic                           fillReq_i,
   input  logic [cachelineSizeInBits-1:0] fillCacheline_i,
   input  logic [tagSize-1:0]             fillTag_i,
   input  logic [indexSize-1:0]           fillIndex_i,
   input  logic [offsetSize-1:0]          fillOffset_i,
   output logic                           fillGrant_o,

   output logic                           fetchEnable_o,
   output logic [tagSize-1:0]             tag_o,
   output logic [indexSize-1:0]           index_o,
   output logic [offsetSize-1:0]          offset_o,

   output logic                           updateEnable_o,
   output logic [cachelineSizeInBits-1:0] newCacheline_o,
   output logic [tagSize-1:0]             newTag_o,
   output logic [indexSize-1:0]           newIndex_o,
   output logic [offsetSize-1:0]          newOffset_o
`ifdef L1I_ARB_PERF_EN
   ,
   output logic [15:0]                    turnaroundCount_o
`endif
);

   localparam int BW = $clog2(fillBurstMax + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(fillBurstMax);

   // State names what was issued in the previous cycle.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_TURN  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [BW-1:0] r_burst;
   logic          w_fetchGrant;
   logic          w_fillGrant;
   logic          w_yieldToFetch;

   function automatic logic [BW-1:0] burst_inc(input logic [BW-1:0] c);
      return (c == BURST_MAX) ? c : c + BW'(1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Grant decision (combinational, first match wins)

   // A fill gives way only when its burst budget is spent and a fetch
   // could actually be granted in its place.
   assign w_yieldToFetch = (r_burst == BURST_MAX) && fetchReq_i && !flushPipeline_i;

   always_comb begin
      w_fetchGrant = 1'b0;
      w_fillGrant  = 1'b0;
      w_next       = ST_IDLE;
      if (reset_i) begin
         w_next = ST_IDLE;
      end else if (fillReq_i && (r_state == ST_READ)) begin
         // The memory needs one idle cycle between a read and a write.
         w_next = ST_TURN;
      end else if (fillReq_i && !w_yieldToFetch) begin
         w_fillGrant = 1'b1;
         w_next      = ST_WRITE;
      end else if (fetchReq_i && !flushPipeline_i) begin
         w_fetchGrant = 1'b1;
         w_next       = ST_READ;
      end
   end

   assign fetchGrant_o = w_fetchGrant;
   assign fillGrant_o  = w_fillGrant;

   // Issue stage: registered memory ports

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state        <= ST_IDLE;
         r_burst        <= '0;
         fetchEnable_o  <= 1'b0;
         tag_o          <= '0;
         index_o        <= '0;
         offset_o       <= '0;
         updateEnable_o <= 1'b0;
         newCacheline_o <= '0;
         newTag_o       <= '0;
         newIndex_o     <= '0;
         newOffset_o    <= '0;
      end else begin
         r_state <= w_next;
         r_burst <= w_fillGrant ? burst_inc(r_burst) : '0;

         // Unused port fields are held at zero because the memory ORs the
         // read and write indices together.
         fetchEnable_o  <= w_fetchGrant;
         tag_o          <= w_fetchGrant ? fetchTag_i    : '0;
         index_o        <= w_fetchGrant ? fetchIndex_i  : '0;
         offset_o       <= w_fetchGrant ? fetchOffset_i : '0;
         updateEnable_o <= w_fillGrant;
         newCacheline_o <= w_fillGrant ? fillCacheline_i : '0;
         newTag_o       <= w_fillGrant ? fillTag_i       : '0;
         newIndex_o     <= w_fillGrant ? fillIndex_i     : '0;
         newOffset_o    <= w_fillGrant ? fillOffset_i    : '0;
      end
   end

`ifdef L1I_ARB_PERF_EN
   logic [15:0] r_turnCount;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_turnCount <= '0;
      end else if (r_state == ST_TURN) begin
         r_turnCount <= sat_inc16(r_turnCount);
      end
   end

   assign turnaroundCount_o = r_turnCount;
`endif

endmodule

// File: doc/l1i_port_arbiter.md
# l1i_port_arbiter

Sequencer and arbiter in front of the single-port L1 instruction cache memory. Merges lookup requests from the fetch stage and cacheline fill requests from the miss handler onto the memory's mutually exclusive read and write ports. Guarantees no read/write collision, including the required one-cycle read-to-write turnaround. Zeroes the unused address fields so the memory's OR-combined index is always correct.

## Interface
Parameters:
- offsetSize, 5, log2 bytes per cacheline
- indexSize, 8, log2 number of cachelines
- tagSize, 64-(offsetSize+indexSize), tag width
- cachelineSizeInBits, (2**offsetSize)*8, line width
- fillBurstMax, 4, max consecutive fill grants while a fetch waits (>=1)

Ports:
- clock_i  in  1  single clock, all logic on posedge
- reset_i  in  1  synchronous, active-high reset
- flushPipeline_i  in  1  pipeline flush
- fetchReq_i  in  1  fetch lookup requested; hold with payload until granted
- fetchTag_i / fetchIndex_i / fetchOffset_i  in  tagSize/indexSize/offsetSize  lookup address
- fetchGrant_o  out  1  combinational; fetch accepted this cycle
- fillReq_i  in  1  fill write requested; hold with payload until granted
- fillCacheline_i  in  cachelineSizeInBits  line data
- fillTag_i / fillIndex_i / fillOffset_i  in  tagSize/indexSize/offsetSize  fill address
- fillGrant_o  out  1  combinational; fill accepted this cycle
- fetchEnable_o, tag_o, index_o, offset_o  out  1/tagSize/indexSize/offsetSize  registered memory read port
- updateEnable_o, newCacheline_o, newTag_o, newIndex_o, newOffset_o  out  1/cachelineSizeInBits/tagSize/indexSize/offsetSize  registered memory write port

## Operation
- Registered state, reflecting the previous cycle's issue: IDLE, READ, WRITE, TURN.
- Grant decision each cycle, first match wins:
  - reset_i: no grants.
  - fillReq_i && state==READ: no grants. Next state TURN (bubble).
  - fillReq_i && !(burstCount==fillBurstMax && fetchReq_i && !flushPipeline_i): fillGrant_o=1. Next state WRITE.
  - fetchReq_i && !flushPipeline_i: fetchGrant_o=1. Next state READ.
  - else: next state IDLE.
- Only one grant may be asserted in any cycle.
- burstCount is ceil(log2(fillBurstMax+1)) bits wide:
  - +1 on each fill grant, saturating at fillBurstMax.
  - Cleared on any cycle without a fill grant.
- Issue on a granted cycle:
  - Fill grant: next cycle updateEnable_o=1, new* fields = fill payload, fetchEnable_o=0, and tag_o/index_o/offset_o all 0.
  - Fetch grant: next cycle fetchEnable_o=1 and read fields = fetch payload. updateEnable_o=0; newCacheline_o, newTag_o, newIndex_o, newOffset_o all 0.
  - No grant: every memory-port output is 0.
- Invariants:
  - fetchEnable_o and updateEnable_o are never both 1.
  - updateEnable_o=1 never follows fetchEnable_o=1 in the immediately preceding cycle.
- Flush:
  - Fetch grants are suppressed while flushPipeline_i=1.
  - Fills are still granted; line data is never dropped.
  - A fetch already registered on the read port still issues.

## Timing
- Reset value of every output is 0; state resets to IDLE and burstCount to 0.
- Grant to memory-port assertion: 1 cycle. Fetch grant to memory cacheline_o valid: 3 cycles.
- Continuous fetches are granted every cycle, 1 per cycle.
- Continuous fills are granted every cycle, 1 per cycle.
- Read-to-write turnaround costs exactly 1 bubble cycle.
- Write-to-read costs no bubble.
- Fetch-starvation bound: a waiting fetch is granted within fillBurstMax+1 cycles of the first fill grant.
- Fill-starvation bound: a waiting fill is granted within 2 cycles.
- Reset asserted mid-stream clears all registers, and the memory ports are 0 on the following cycle. A request held across reset is granted only after reset deasserts.

## Configuration
- L1I_ARB_PERF_EN defined:
  - Adds output turnaroundCount_o [16 bits], a saturating count of TURN-state cycles.
  - Cleared by reset_i; not cleared by flush.
- L1I_ARB_PERF_EN undefined: the port and counter logic do not exist.

## Test plan
- Reset, then fetchReq_i=1 with index 0x12: fetchGrant_o=1 that cycle; next cycle fetchEnable_o=1, index_o=0x12, newIndex_o=0, updateEnable_o=0.
- Fetch granted in cycle n, fillReq_i raised in n+1: no grant in n+1 (TURN). fillGrant_o in n+2; updateEnable_o=1 in n+3, while fetchEnable_o=1 was in n+1 only.
- fillReq_i and fetchReq_i both held, fillBurstMax=4: grants are fill×4, fetch, bubble, fill×4, repeating.
- Fill in progress, fetchReq_i=1 with flushPipeline_i=1 for 3 cycles: fills continue each cycle, fetchGrant_o stays 0. The fetch is granted the first cycle after the flush drops with no pending fill.
- reset_i pulsed while fill and fetch outputs are active: every output is 0 the next cycle and state is IDLE. With L1I_ARB_PERF_EN, after 3 turnarounds turnaroundCount_o=3, and it returns to 0 on reset.
